// File: rtl/zeroriscy_multdiv_ctrl_if.sv
// ----------------------------------------------------------------------------
// zeroriscy_multdiv_ctrl_if
//
// Bundles the request, kill, unit-control and response signals of the
// mult/div issue controller. Signal names match the original flat ports so
// connections read the same as before.
//
//   master : ID stage + mult/div unit side (drives request and unit result)
//   slave  : zeroriscy_multdiv_ctrl
//
//   req_valid_i / req_ready_o       op offer / accept (ready high in IDLE)
//   funct3_i, op_a_i, op_b_i        RV32M funct3 and rs1/rs2 values
//   kill_i                          flush of the offered or in-flight op
//   busy_o                          stall to ID
//   md_mult_en_o / md_div_en_o      unit enables
//   md_operator_o, md_signed_mode_o decoded operator and operand signedness
//   md_op_a_o, md_op_b_o            held operands
//   md_equal_to_zero_o              held op_b is zero
//   md_result_i / md_ready_i        unit result and result-valid
//   rsp_valid_o / rsp_data_o        writeback pulse and held result
//   err_o                           sticky timeout flag
// ----------------------------------------------------------------------------
interface zeroriscy_multdiv_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        busy_o;
    logic        md_mult_en_o;
    logic        md_div_en_o;
    logic [1:0]  md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o;
    logic [31:0] md_op_b_o;
    logic        md_equal_to_zero_o;
    logic [31:0] md_result_i;
    logic        md_ready_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        err_o;

    modport master (
        output req_valid_i, funct3_i, op_a_i, op_b_i, kill_i,
        output md_result_i, md_ready_i,
        input  req_ready_o, busy_o, md_mult_en_o, md_div_en_o,
        input  md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o,
        input  md_equal_to_zero_o, rsp_valid_o, rsp_data_o, err_o
    );

    modport slave (
        input  req_valid_i, funct3_i, op_a_i, op_b_i, kill_i,
        input  md_result_i, md_ready_i,
        output req_ready_o, busy_o, md_mult_en_o, md_div_en_o,
        output md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o,
        output md_equal_to_zero_o, rsp_valid_o, rsp_data_o, err_o
    );
endinterface

// File: rtl/zeroriscy_multdiv_ctrl.sv
// ----------------------------------------------------------------------------
// zeroriscy_multdiv_ctrl
//
// Issue-side controller for the fast mult/div unit in the EX stage. Accepts
// one RV32M op from ID, decodes funct3 into operator/signed_mode, and holds
// operands and the unit enable stable until the unit reports ready. Killed
// in-flight ops are drained (the unit cannot be aborted) and produce no
// response. A completed op returns one registered result pulse to writeback.
//
// Parameters
//   TIMEOUT_CYCLES  enabled cycles per op after which err_o sets (sticky)
//
// Ports
//   clk    clock
//   rst_n  asynchronous active-low reset (the unit shares it)
//   bus    zeroriscy_multdiv_ctrl_if.slave (request, unit and response side)
// ----------------------------------------------------------------------------
module zeroriscy_multdiv_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic                      clk,
    input  logic                      rst_n,
    zeroriscy_multdiv_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    localparam logic [5:0] TIMEOUT_LIMIT = 6'(TIMEOUT_CYCLES);

    state_e      state;

    md_op_e      dec_operator;
    logic [1:0]  dec_signed_mode;
    logic        dec_is_mult;

    logic        mult_en_q;
    logic        div_en_q;
    logic [1:0]  operator_q;
    logic [1:0]  signed_mode_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic        eq_zero_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        err_q;

    logic [5:0]  tmo_cnt;
    logic [5:0]  tmo_cnt_inc;
    logic        unit_enabled;

    // funct3 -> {operator, signed_mode}; signed_mode[0] is op_a, [1] is op_b.
    always_comb begin
        dec_operator    = MD_OP_MULL;
        dec_signed_mode = 2'b00;
        unique case (bus.funct3_i)
            3'b000: begin dec_operator = MD_OP_MULL; dec_signed_mode = 2'b00; end
            3'b001: begin dec_operator = MD_OP_MULH; dec_signed_mode = 2'b11; end
            3'b010: begin dec_operator = MD_OP_MULH; dec_signed_mode = 2'b01; end
            3'b011: begin dec_operator = MD_OP_MULH; dec_signed_mode = 2'b00; end
            3'b100: begin dec_operator = MD_OP_DIV;  dec_signed_mode = 2'b11; end
            3'b101: begin dec_operator = MD_OP_DIV;  dec_signed_mode = 2'b00; end
            3'b110: begin dec_operator = MD_OP_REM;  dec_signed_mode = 2'b11; end
            3'b111: begin dec_operator = MD_OP_REM;  dec_signed_mode = 2'b00; end
            default: begin dec_operator = MD_OP_MULL; dec_signed_mode = 2'b00; end
        endcase
    end

    assign dec_is_mult  = (dec_operator == MD_OP_MULL) || (dec_operator == MD_OP_MULH);
    assign unit_enabled = mult_en_q | div_en_q;

    // Saturating increment so a stuck unit cannot wrap the counter back below
    // the limit.
    assign tmo_cnt_inc  = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mult_en_q     <= 1'b0;
            div_en_q      <= 1'b0;
            operator_q    <= '0;
            signed_mode_q <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            eq_zero_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            err_q         <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;

            // Counts every cycle the unit is enabled, including drain cycles.
            if (unit_enabled) begin
                tmo_cnt <= tmo_cnt_inc;
                if (tmo_cnt_inc >= TIMEOUT_LIMIT) begin
                    err_q <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (bus.req_valid_i && !bus.kill_i) begin
                        op_a_q        <= bus.op_a_i;
                        op_b_q        <= bus.op_b_i;
                        eq_zero_q     <= (bus.op_b_i == '0);
                        operator_q    <= dec_operator;
                        signed_mode_q <= dec_signed_mode;
                        mult_en_q     <= dec_is_mult;
                        div_en_q      <= !dec_is_mult;
                        tmo_cnt       <= '0;
                        state         <= ST_BUSY;
                    end
                end

                // Enable stays high through the md_ready_i cycle so the unit
                // can return to its start state, then drops with the exit.
                ST_BUSY: begin
                    if (bus.md_ready_i) begin
                        if (!bus.kill_i) begin
                            rsp_data_q  <= bus.md_result_i;
                            rsp_valid_q <= 1'b1;
                        end
                        mult_en_q <= 1'b0;
                        div_en_q  <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (bus.kill_i) begin
                        state <= ST_DRAIN;
                    end
                end

                // Killed op still running in the unit; result is discarded.
                ST_DRAIN: begin
                    if (bus.md_ready_i) begin
                        mult_en_q <= 1'b0;
                        div_en_q  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    mult_en_q <= 1'b0;
                    div_en_q  <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o        = (state == ST_IDLE);
    assign bus.busy_o             = (state != ST_IDLE);
    assign bus.md_mult_en_o       = mult_en_q;
    assign bus.md_div_en_o        = div_en_q;
    assign bus.md_operator_o      = operator_q;
    assign bus.md_signed_mode_o   = signed_mode_q;
    assign bus.md_op_a_o          = op_a_q;
    assign bus.md_op_b_o          = op_b_q;
    assign bus.md_equal_to_zero_o = eq_zero_q;
    assign bus.rsp_valid_o        = rsp_valid_q;
    assign bus.rsp_data_o         = rsp_data_q;
    assign bus.err_o              = err_q;

endmodule

// File: tb/tb_zeroriscy_multdiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_zeroriscy_multdiv_ctrl
//
// Directed bench for the mult/div issue controller. The bench stands in for
// the mult/div unit: it raises md_ready_i with a hand-computed result after
// the unit latency for each op, and drives garbage on md_result_i otherwise.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_zeroriscy_multdiv_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    zeroriscy_multdiv_ctrl_if bus ();

    zeroriscy_multdiv_ctrl #(.TIMEOUT_CYCLES(40)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_rsp = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Offer an op at the current falling edge; return at the falling edge of
    // the first enabled cycle after checking the latched controls.
    task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] exp_op,
                         input logic [1:0] exp_sm, input logic exp_mul);
        bus.req_valid_i = 1'b1;
        bus.funct3_i    = f3;
        bus.op_a_i      = a;
        bus.op_b_i      = b;
        check($sformatf("%s.req_ready", tag), 32'(bus.req_ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Disturb the inputs to show the latched copies are held.
        bus.req_valid_i = 1'b0;
        bus.funct3_i    = ~f3;
        bus.op_a_i      = ~a;
        bus.op_b_i      = ~b;
        check($sformatf("%s.busy", tag),      32'(bus.busy_o),           32'd1);
        check($sformatf("%s.req_ready1", tag), 32'(bus.req_ready_o),     32'd0);
        check($sformatf("%s.operator", tag),  32'(bus.md_operator_o),    32'(exp_op));
        check($sformatf("%s.signed", tag),    32'(bus.md_signed_mode_o), 32'(exp_sm));
        check($sformatf("%s.op_a", tag),      bus.md_op_a_o,             a);
        check($sformatf("%s.op_b", tag),      bus.md_op_b_o,             b);
        check($sformatf("%s.eq0", tag),       32'(bus.md_equal_to_zero_o), 32'(b == 32'd0));
        check($sformatf("%s.rsp_hold", tag),  bus.rsp_data_o,            last_rsp);
    endtask

    // Play the unit for lat enabled cycles; kill_i is high from kill_at to
    // lat inclusive when kill_at != 0. Returns at the cycle after md_ready_i.
    task automatic complete(input string tag, input int lat, input logic [31:0] res,
                            input int kill_at, input logic exp_mul);
        for (int c = 1; c <= lat; c++) begin
            check($sformatf("%s.mul_en[%0d]", tag, c), 32'(bus.md_mult_en_o), 32'(exp_mul));
            check($sformatf("%s.div_en[%0d]", tag, c), 32'(bus.md_div_en_o),  32'(!exp_mul));
            check($sformatf("%s.rsp_v[%0d]", tag, c),  32'(bus.rsp_valid_o),  32'd0);
            bus.kill_i      = (kill_at != 0) && (c >= kill_at);
            bus.md_ready_i  = (c == lat);
            bus.md_result_i = (c == lat) ? res : ~res;
            @(negedge clk);
        end
        bus.kill_i      = 1'b0;
        bus.md_ready_i  = 1'b0;
        bus.md_result_i = 32'h5A5A_5A5A;
        if (kill_at == 0) last_rsp = res;
        check($sformatf("%s.mul_en_off", tag), 32'(bus.md_mult_en_o), 32'd0);
        check($sformatf("%s.div_en_off", tag), 32'(bus.md_div_en_o),  32'd0);
        check($sformatf("%s.busy_off", tag),   32'(bus.busy_o),       32'd0);
        check($sformatf("%s.rsp_valid", tag),  32'(bus.rsp_valid_o),  32'(kill_at == 0));
        check($sformatf("%s.rsp_data", tag),   bus.rsp_data_o,        last_rsp);
        check($sformatf("%s.err", tag),        32'(bus.err_o),        32'd0);
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.funct3_i    = '0;
        bus.op_a_i      = '0;
        bus.op_b_i      = '0;
        bus.kill_i      = 1'b0;
        bus.md_result_i = '0;
        bus.md_ready_i  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst.req_ready", 32'(bus.req_ready_o),        32'd1);
        check("rst.busy",      32'(bus.busy_o),             32'd0);
        check("rst.mul_en",    32'(bus.md_mult_en_o),       32'd0);
        check("rst.div_en",    32'(bus.md_div_en_o),        32'd0);
        check("rst.operator",  32'(bus.md_operator_o),      32'd0);
        check("rst.op_a",      bus.md_op_a_o,               32'd0);
        check("rst.eq0",       32'(bus.md_equal_to_zero_o), 32'd0);
        check("rst.rsp_valid", 32'(bus.rsp_valid_o),        32'd0);
        check("rst.rsp_data",  bus.rsp_data_o,              32'd0);
        check("rst.err",       32'(bus.err_o),              32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Each op is offered in the response cycle of the previous one.
        issue("mul", 3'b000, 32'h0001_0003, 32'h0002_0005, 2'b00, 2'b00, 1'b1);
        complete("mul", 3, 32'h000B_000F, 0, 1'b1);
        issue("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 2'b01, 2'b11, 1'b1);
        complete("mulh", 4, 32'h4000_0000, 0, 1'b1);
        issue("mulhu", 3'b011, 32'h8000_0000, 32'h8000_0000, 2'b01, 2'b00, 1'b1);
        complete("mulhu", 4, 32'h4000_0000, 0, 1'b1);
        issue("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000, 2'b01, 2'b01, 1'b1);
        complete("mulhsu", 4, 32'hC000_0000, 0, 1'b1);
        issue("div", 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 2'b10, 2'b11, 1'b0);
        complete("div", 37, 32'hFFFF_FFFD, 0, 1'b0);
        issue("rem", 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 2'b11, 2'b11, 1'b0);
        complete("rem", 37, 32'hFFFF_FFFF, 0, 1'b0);
        issue("divu0", 3'b101, 32'h0000_0005, 32'h0000_0000, 2'b10, 2'b00, 1'b0);
        complete("divu0", 2, 32'hFFFF_FFFF, 0, 1'b0);
        issue("remu0", 3'b111, 32'h0000_0005, 32'h0000_0000, 2'b11, 2'b00, 1'b0);
        complete("remu0", 2, 32'h0000_0005, 0, 1'b0);

        // Offer together with kill: not accepted.
        bus.req_valid_i = 1'b1;
        bus.kill_i      = 1'b1;
        bus.funct3_i    = 3'b000;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.kill_i      = 1'b0;
        check("killoffer.busy",   32'(bus.busy_o),       32'd0);
        check("killoffer.ready",  32'(bus.req_ready_o),  32'd1);
        check("killoffer.mul_en", 32'(bus.md_mult_en_o), 32'd0);
        check("killoffer.rsp",    32'(bus.rsp_valid_o),  32'd0);

        // Kill in BUSY at enabled cycle 10: drain to ready, no response.
        issue("divkill", 3'b100, 32'h0000_0064, 32'h0000_0007, 2'b10, 2'b11, 1'b0);
        complete("divkill", 37, 32'h0000_000E, 10, 1'b0);
        issue("mul2", 3'b000, 32'h0000_0006, 32'h0000_0007, 2'b00, 2'b00, 1'b1);
        complete("mul2", 3, 32'h0000_002A, 0, 1'b1);

        // Kill coinciding with md_ready_i in BUSY: result discarded.
        issue("mulkr", 3'b000, 32'h0000_0009, 32'h0000_0009, 2'b00, 2'b00, 1'b1);
        complete("mulkr", 3, 32'h0000_0051, 3, 1'b1);

        // Stub unit never ready: err_o after 40 enabled cycles, sticky.
        issue("tmo", 3'b000, 32'h0000_0001, 32'h0000_0001, 2'b00, 2'b00, 1'b1);
        for (int c = 1; c < 40; c++) @(negedge clk);
        check("tmo.err_c40", 32'(bus.err_o), 32'd0);
        @(negedge clk);
        check("tmo.err_c41", 32'(bus.err_o),        32'd1);
        check("tmo.busy",    32'(bus.busy_o),       32'd1);
        repeat (5) @(negedge clk);
        check("tmo.err_sticky", 32'(bus.err_o),        32'd1);
        check("tmo.mul_en",     32'(bus.md_mult_en_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("tmo.rst_err",    32'(bus.err_o),        32'd0);
        check("tmo.rst_busy",   32'(bus.busy_o),       32'd0);
        check("tmo.rst_mul_en", 32'(bus.md_mult_en_o), 32'd0);
        check("tmo.rst_ready",  32'(bus.req_ready_o),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
